// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for the Phase 1 datapath.
// Steps IDLE/T0..T5/HALT and decodes IR into register enables, bus selects and ALU op.
//
// Ports:
//   clk, clr         - clock, synchronous active-high reset
//   run              - level start/continue request
//   IR               - instruction word held by the datapath
//   enable           - register load enables (R0..R15, PC, MDR, IR, Z, MAR, Y)
//   busSelect        - one-hot bus driver select (R0..R15, Zlow, PC, MDR)
//   MR_Read, IncPC   - MDR memory-select, PC increment
//   Control_Signals  - ALU operation code
//   state            - current state encoding
//   instr_done       - pulse in the last execute state
//   halted           - high while in HALT
module control_sequencer #(
  parameter int NREG = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] IR,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic        MR_Read,
  output logic        IncPC,
  output logic [3:0]  Control_Signals,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        halted
);

  localparam int EN_PC   = 20;
  localparam int EN_MDR  = 21;
  localparam int EN_IR   = 23;
  localparam int EN_Z    = 24;
  localparam int EN_MAR  = 25;
  localparam int EN_Y    = 27;
  localparam int BS_ZLO  = 19;
  localparam int BS_PC   = 20;
  localparam int BS_MDR  = 21;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd7,
    S_T1   = 4'd8,
    S_T2   = 4'd9,
    S_T3   = 4'd10,
    S_T4   = 4'd11,
    S_T5   = 4'd12,
    S_HALT = 4'd13
  } state_t;

  state_t state_q, state_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        is_alu, is_halt;
  logic [31:0] ra_sel, rb_sel, rc_sel;

  assign opcode  = IR[31:27];
  assign ra      = IR[26:23];
  assign rb      = IR[22:19];
  assign rc      = IR[18:15];
  assign is_alu  = (opcode >= 5'd3) && (opcode <= 5'd12);
  assign is_halt = (opcode == 5'd31);

  // Out-of-range register fields select nothing.
  assign ra_sel = (int'(ra) < NREG) ? (32'd1 << ra) : '0;
  assign rb_sel = (int'(rb) < NREG) ? (32'd1 << rb) : '0;
  assign rc_sel = (int'(rc) < NREG) ? (32'd1 << rc) : '0;

  always_comb begin
    state_d         = state_q;
    enable          = '0;
    busSelect       = '0;
    MR_Read         = 1'b0;
    IncPC           = 1'b0;
    Control_Signals = 4'd0;
    instr_done      = 1'b0;
    halted          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        busSelect[BS_PC] = 1'b1;
        enable[EN_MAR]   = 1'b1;
        enable[EN_PC]    = 1'b1;
        IncPC            = 1'b1;
        state_d          = S_T1;
      end
      S_T1: begin
        MR_Read        = 1'b1;
        enable[EN_MDR] = 1'b1;
        state_d        = S_T2;
      end
      S_T2: begin
        busSelect[BS_MDR] = 1'b1;
        enable[EN_IR]     = 1'b1;
        state_d           = S_T3;
      end
      S_T3: begin
        unique case (1'b1)
          is_alu: begin
            busSelect    = rb_sel;
            enable[EN_Y] = 1'b1;
            state_d      = S_T4;
          end
          is_halt: state_d = S_HALT;
          default: begin
            instr_done = 1'b1;
            state_d    = run ? S_T0 : S_IDLE;
          end
        endcase
      end
      S_T4: begin
        busSelect       = rc_sel;
        enable[EN_Z]    = 1'b1;
        Control_Signals = 4'(opcode - 5'd1);
        state_d         = S_T5;
      end
      S_T5: begin
        busSelect[BS_ZLO] = 1'b1;
        enable            = ra_sel;
        instr_done        = 1'b1;
        state_d           = run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the Phase 1 datapath. It steps through the fetch/execute states T0–T5 and drives the datapath's register `enable` vector, `busSelect` vector, `MR_Read` and the 4-bit ALU control. Those signals are currently hand-driven by the datapath test benches. It decodes the 32-bit IR word captured by the datapath and sequences three-register ALU instructions (add, sub, shl, …) to completion. It sits beside `Datapath` and connects to it port-for-port.

## Interface
Parameters:
- `NREG`, 16, number of general registers R0..R(NREG-1), mapped to enable/busSelect bits 0..NREG-1.

Ports:
- `clk` in 1: sole clock, rising-edge.
- `clr` in 1: synchronous, active-high reset.
- `run` in 1: level; start/continue instruction execution.
- `IR` in 32: instruction register contents from the datapath.
- `enable` out 32: register load enables.
  - Bits 0–15: R0–R15.
  - Bit 20: PC. Bit 21: MDR. Bit 23: IR. Bit 24: Z. Bit 25: MAR. Bit 27: Y.
- `busSelect` out 32: one-hot bus driver select.
  - Bits 0–15: R0–R15.
  - Bit 19: Zlow. Bit 20: PC. Bit 21: MDR.
- `MR_Read` out 1: MDR input mux selects memory data.
- `IncPC` out 1: ALU performs PC+1 while PC is on the bus.
- `Control_Signals` out 4: ALU operation code.
- `state` out 4: current state encoding, for debug.
- `instr_done` out 1: one-cycle pulse in the last execute state.
- `halted` out 1: high while in HALT.

## Operation
- States and encodings: IDLE=0, T0=7, T1=8, T2=9, T3=10, T4=11, T5=12, HALT=13.
- Moore machine: all outputs decode from the registered state plus `IR`. Any bit not listed for a state is 0.
- IDLE: all outputs 0. Go to T0 when `run`=1; otherwise stay in IDLE.
- T0 (fetch address):
  - `busSelect[20]`=1; `enable[25]`=1, `enable[20]`=1; `IncPC`=1.
  - Next state: T1.
- T1 (memory read):
  - `MR_Read`=1, `enable[21]`=1.
  - Next state: T2.
- T2 (load IR):
  - `busSelect[21]`=1, `enable[23]`=1.
  - Next state: T3.
- IR decode, valid from T3 onward:
  - opcode = IR[31:27]; Ra = IR[26:23]; Rb = IR[22:19]; Rc = IR[18:15].
- Opcode classes:
  - ALU opcodes 3–12: `Control_Signals` = opcode − 1 (add=3→2, shl=9→8).
  - Opcode 31: halt.
  - All other opcodes: NOP.
- T3:
  - ALU opcode: `busSelect[Rb]`=1, `enable[27]`=1; next state T4.
  - Halt: next state HALT, no outputs asserted.
  - NOP: `instr_done`=1; next state T0 if `run`, else IDLE.
- T4:
  - `busSelect[Rc]`=1, `enable[24]`=1, `Control_Signals` driven for the decoded opcode.
  - `Control_Signals` is 0 in every other state.
  - Next state: T5.
- T5:
  - `busSelect[19]`=1, `enable[Ra]`=1, `instr_done`=1.
  - Next state: T0 if `run`=1, else IDLE.
- HALT: `halted`=1, all other outputs 0. Leave only via `clr`.
- Register index fields ≥ NREG: no enable or busSelect bit is set for that field. The state sequence is unchanged.
- `busSelect` is one-hot or all-zero in every state. It is never multi-hot.

## Timing
- Reset: on a `clk` edge with `clr`=1, state becomes IDLE, regardless of current state (mid-instruction included).
  - From the next cycle, every output is 0, `state`=0 and `halted`=0.
  - `clr` has priority over `run`.
- Latencies:
  - ALU instruction: 6 cycles (T0–T5).
  - NOP: 4 cycles (T0–T3).
  - Back-to-back instructions with `run` held high: no idle cycle between T5/T3 and the next T0.
- `run` is sampled only in IDLE, T5 and T3-NOP. Deasserting `run` elsewhere does not abort the current instruction.
- Memory is single-cycle: data is valid at the MDR input throughout T1. There is no wait-state handshake.
- `IR` must be stable from the T2→T3 edge through T5. The datapath guarantees this, because IR is loaded only in T2.
- Each output is valid for the full cycle of its state. The datapath captures on the `clk` edge that ends the state.

## Test plan
- **Reset:** hold `clr`=1 for 2 cycles with `run`=1.
  - Required: `state`=0 and `enable`=`busSelect`=0, `MR_Read`=0, `IncPC`=0, `Control_Signals`=0, `halted`=0.
  - Release `clr`: T0 follows one cycle later.
- **SHL sequence:** `run`=1, `IR`=0x489A8000 (shl R1,R3,R5).
  - T0: `busSelect`=0x00100000, `enable`=0x02100000, `IncPC`=1.
  - T1: `enable`=0x00200000, `MR_Read`=1.
  - T2: `busSelect`=0x00200000, `enable`=0x00800000.
  - T3: `busSelect`=0x00000008, `enable`=0x08000000.
  - T4: `busSelect`=0x00000020, `enable`=0x01000000, `Control_Signals`=8.
  - T5: `busSelect`=0x00080000, `enable`=0x00000002, `instr_done`=1.
- **Run release:** drop `run` during T3 of an add (`IR`=0x18000000 | fields).
  - Required: the instruction completes through T5 with `Control_Signals`=2 in T4, then IDLE.
- **NOP:** `IR` opcode 0.
  - Required: T3 asserts only `instr_done`, then T0 with `run`=1. No T4/T5 visited.
- **Halt:** `IR`=0xF8000000.
  - Required: T3 → HALT, and `halted` stays 1 for 10 cycles with `run`=1.
  - `clr` then returns the block to IDLE.
- **Mid-instruction reset:** assert `clr` in T4.
  - Required: the next cycle is IDLE with all outputs 0. No Ra write-back occurs.
